// File: rtl/mod_pipe_pkg.sv
// Shared definitions for the modulation pipe: default word width, sequencer
// state encoding and the zero word forwarded for a lost segment.
package mod_pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } seq_state_t;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

    // Width able to hold 0..limit inclusive.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mod_segment_sequencer_timeout.sv
// Per-segment WAIT watchdog: cleared on issue, counts while enabled and flags
// the cycle on which the segment result is declared lost.
module seg_timeout_counter
    import mod_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = cnt_width(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(TIMEOUT))) begin
            // Saturate so a stuck enable can never wrap back below the limit.
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mod_segment_sequencer.sv
// Walks NUM_SEG segment calculations per accepted symbol: start pulse, wait for
// the segment result (or time out), then forward it downstream over valid/ready.
module mod_segment_sequencer
    import mod_pipe_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned NUM_SEG   = 8,
    parameter int unsigned SEG_IDX_W = $clog2(NUM_SEG),
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    input  logic [DATA_W-1:0]    input_bit,
    output logic                 seg_start,
    output logic [SEG_IDX_W-1:0] seg_idx,
    output logic                 seg_sel,
    input  logic                 seg_valid,
    input  logic [DATA_W-1:0]    seg_data,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 error
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    seq_state_t state;
    logic       seg_expire;
    logic       is_last;
    logic       unused_sym_bits;

    // Only bit 0 of the symbol steers the branch; the rest is carried for width.
    assign unused_sym_bits = ^input_bit[DATA_W-1:1];

    assign is_last   = (seg_idx == SEG_IDX_W'(NUM_SEG - 1));
    assign bit_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    seg_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ISSUE),
        .enable (state == WAIT),
        .expire (seg_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            seg_idx   <= '0;
            seg_sel   <= 1'b0;
            seg_start <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            error     <= 1'b0;
        end else begin
            seg_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bit_valid) begin
                        seg_sel   <= input_bit[0];
                        seg_idx   <= '0;
                        seg_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the expiry cycle still wins.
                    if (seg_valid) begin
                        out_data  <= seg_data;
                        out_valid <= 1'b1;
                        out_last  <= is_last;
                        state     <= OUT;
                    end else if (seg_expire) begin
                        out_data  <= DATA_W'(ZERO_WORD);
                        out_valid <= 1'b1;
                        out_last  <= is_last;
                        error     <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (is_last) begin
                            state <= IDLE;
                        end else begin
                            // Start pulse is registered, so it lands in ISSUE.
                            seg_idx   <= seg_idx + SEG_IDX_W'(1);
                            seg_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mod_segment_sequencer.md
Name: mod_segment_sequencer

Overview:
- Controller for the modulation pipe's per-segment if/else calculation blocks.
- Accepts one modulation symbol (input_bit word) over a valid/ready handshake, then walks NUM_SEG segment indices.
- For each segment: fires one start pulse with branch select derived from bit 0, waits for the segment's valid (delay-line latency), and forwards the segment word downstream over valid/ready.
- Owns busy/error status for the segment datapath; sits between the symbol source and the waveform assembler.

Parameters:
DATA_W, 32, width of symbol word and segment data
NUM_SEG, 8, segments per symbol (>=2)
SEG_IDX_W, $clog2(NUM_SEG), segment index width (derived)
TIMEOUT, 15, max WAIT cycles before segment is declared lost (>=SEG_LAT+1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
bit_valid  in  1  symbol word available
bit_ready  out  1  sequencer can accept symbol
input_bit  in  DATA_W  symbol word; only bit 0 selects branch
seg_start  out  1  one-cycle start pulse to segment calculation block
seg_idx  out  SEG_IDX_W  segment index being computed
seg_sel  out  1  1 = if-branch (array_ref_wire), 0 = else-branch (array_ref_m_wire)
seg_valid  in  1  segment result valid
seg_data  in  DATA_W  segment result
out_data  out  DATA_W  forwarded segment word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_last  out  1  marks last segment of symbol (qualified by out_valid)
busy  out  1  state != IDLE
error  out  1  sticky: at least one segment timed out

Behaviour:
- Reset (async, immediate): state=IDLE, seg_idx=0, seg_sel=0, seg_start=0, out_data=0, out_valid=0, out_last=0, error=0, timeout counter=0. bit_ready=1 after reset (combinational from IDLE).
- IDLE: bit_ready=1. On bit_valid&bit_ready, register seg_sel<=input_bit[0], seg_idx<=0 -> ISSUE.
- ISSUE: seg_start=1 for exactly this cycle. Timeout counter cleared -> WAIT.
- WAIT: counter increments each cycle.
  - seg_valid=1: out_data<=seg_data, out_valid<=1 -> OUT.
  - Else if counter==TIMEOUT-1: out_data<=0 (zero word), out_valid<=1, error<=1 -> OUT.
  - seg_valid on the same cycle as timeout: valid wins; no error.
- OUT: out_valid and out_data held stable until out_ready. out_last=1 iff seg_idx==NUM_SEG-1. On handshake, out_valid<=0.
  - Last segment -> IDLE.
  - Otherwise seg_idx<=seg_idx+1 -> ISSUE.
- seg_valid outside WAIT is ignored.
- No seg_start is issued while OUT is stalled; the segment block is never restarted with data pending.
- seg_sel is constant for the whole symbol. bit_valid is ignored outside IDLE.
- Timing (SEG_LAT = segment block latency, out_ready=1):
  - Accept at T0, seg_start at T0+1, seg_valid at T0+1+SEG_LAT, out_valid at T0+2+SEG_LAT.
  - Next seg_start the cycle after the handshake. Period per segment = SEG_LAT+2 cycles.
- After the last handshake, IDLE the next cycle with bit_ready=1; no back-to-back overlap between symbols.
- error is cleared only by reset.
- seg_idx does not wrap; the last index returns to IDLE and seg_idx is reset on the next accept.

Decomposition:
- Shared package mod_pipe_pkg: DATA_W default, state enum {IDLE, ISSUE, WAIT, OUT}, zero-word constant.
- One sub-module, seg_timeout_counter: clear/enable/expire, width $clog2(TIMEOUT+1), async reset.
- FSM, index counter and output registers stay in the top.

Test Plan:
1. Reset: assert reset mid-cycle -> all outputs 0 immediately; bit_ready=1, busy=0 after release.
2. Nominal: input_bit=0x1, seg model returns 0x100+idx one cycle after seg_start, out_ready=1 -> 8 beats 0x100..0x107, seg_sel=1, seg_start spaced 3 cycles, out_last only on 0x107, bit_ready=1 one cycle later.
3. Else branch: input_bit=0xFFFFFFFE -> seg_sel=0 for all 8 segments, same data ordering, error=0.
4. Backpressure: out_ready low 5 cycles on beat idx=3 -> out_data=0x103 held, no seg_start during stall, idx=4 issued the cycle after handshake.
5. Timeout: model withholds seg_valid for idx=2 -> after 15 WAIT cycles out_data=0, error=1 sticky; idx 3..7 proceed normally. Separately, seg_valid on the 15th cycle -> data forwarded, error stays 0.
6. Reset in WAIT at idx=5, then a late seg_valid -> ignored, out_valid=0; next symbol starts at idx=0.
